// File: rtl/mux_2x1_rr_arb_if.sv
// ---------------------------------------------------------------------------
// mux_2x1_rr_arb_if
// Bundles the two input streams and the registered output stream of the
// mux_2x1_rr_arb round-robin arbiter.
//
// Handshake: a beat moves on a rising clock edge when valid and ready are both
// high in the cycle before that edge. A producer keeps data/last stable while
// valid is high and ready is low. Ready may depend combinationally on valid.
//
// Signals:
//   in0_valid/in0_data/in0_last/in0_ready  channel 0 input stream
//   in1_valid/in1_data/in1_last/in1_ready  channel 1 input stream
//   out_valid/out_data/out_last/out_ready  registered output stream
//   out_sel                                source channel of the output beat
// Modports:
//   master : environment view (drives the inputs and out_ready)
//   slave  : arbiter view
// ---------------------------------------------------------------------------
interface mux_2x1_rr_arb_if #(
  parameter int WIDTH = 8
);
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_last;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_last;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_sel;
  logic             out_ready;

  modport master (
    output in0_valid, in0_data, in0_last,
    input  in0_ready,
    output in1_valid, in1_data, in1_last,
    input  in1_ready,
    input  out_valid, out_data, out_last, out_sel,
    output out_ready
  );

  modport slave (
    input  in0_valid, in0_data, in0_last,
    output in0_ready,
    input  in1_valid, in1_data, in1_last,
    output in1_ready,
    output out_valid, out_data, out_last, out_sel,
    input  out_ready
  );
endinterface

// File: rtl/mux_2x1_rr_arb.sv
// ---------------------------------------------------------------------------
// mux_2x1_rr_arb
// Two-channel round-robin stream arbiter with a one-deep registered output
// slot. Multi-beat packets (terminated by last=1) are never interleaved: once
// a non-last beat is taken from a channel, the arbiter locks onto it until its
// last beat. out_sel tells the downstream 2x1 mux stage which channel the
// current output beat came from.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   bus        mux_2x1_rr_arb_if.slave (input streams, output stream, out_sel)
//   state_dbg  current FSM state: 0=ARB, 1=LOCK0, 2=LOCK1
//   prio_dbg   round-robin pointer (channel preferred when both request)
//
// Optional build macro MUX_RR_ARB_STATS_EN adds:
//   stats_clr  synchronous clear of both packet counters (wins over counting)
//   pkt_cnt0   saturating count of accepted last beats on channel 0
//   pkt_cnt1   saturating count of accepted last beats on channel 1
// ---------------------------------------------------------------------------
module mux_2x1_rr_arb #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_2x1_rr_arb_if.slave       bus,
  output logic [1:0]            state_dbg,
  output logic                  prio_dbg
`ifdef MUX_RR_ARB_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [15:0]           pkt_cnt0,
  output logic [15:0]           pkt_cnt1
`endif
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic             out_sel_q;

  logic             load_en;
  logic             gnt_vld;
  logic             gnt;
  logic             accept;
  logic             acc_last;
  logic [WIDTH-1:0] acc_data;

  // Slot can take a beat when it is empty or being drained this cycle.
  assign load_en = !out_valid_q || bus.out_ready;

  // Grant: in a lock only the owning channel may be granted, even when idle.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    case (state_q)
      ARB: begin
        if (bus.in0_valid && bus.in1_valid) begin
          gnt_vld = 1'b1;
          gnt     = prio_q;
        end else if (bus.in0_valid) begin
          gnt_vld = 1'b1;
          gnt     = 1'b0;
        end else if (bus.in1_valid) begin
          gnt_vld = 1'b1;
          gnt     = 1'b1;
        end
      end
      LOCK0: begin
        gnt_vld = bus.in0_valid;
        gnt     = 1'b0;
      end
      LOCK1: begin
        gnt_vld = bus.in1_valid;
        gnt     = 1'b1;
      end
      default: begin
        gnt_vld = 1'b0;
        gnt     = 1'b0;
      end
    endcase
  end

  // A grant always implies the granted valid is high, so accept is the
  // handshake itself. No beat is taken while reset is held: the slot is
  // being cleared and could not capture it.
  assign accept        = load_en && gnt_vld && !rst;
  assign bus.in0_ready = accept && !gnt;
  assign bus.in1_ready = accept && gnt;
  assign acc_data      = gnt ? bus.in1_data : bus.in0_data;
  assign acc_last      = gnt ? bus.in1_last : bus.in0_last;

  // Next state / pointer: a last beat ends the packet and hands priority to
  // the other channel; a non-last beat locks onto the granted channel.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (accept) begin
      if (acc_last) begin
        state_d = ARB;
        prio_d  = ~gnt;
      end else begin
        state_d = gnt ? LOCK1 : LOCK0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      // Drain without load clears only valid; payload and sel hold.
      if (load_en) begin
        out_valid_q <= accept;
        if (accept) begin
          out_data_q <= acc_data;
          out_last_q <= acc_last;
          out_sel_q  <= gnt;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;
  assign state_dbg     = state_q;
  assign prio_dbg      = prio_q;

`ifdef MUX_RR_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (stats_clr) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (accept && acc_last) begin
      if (!gnt && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
      if (gnt && (cnt1_q != 16'hFFFF))  cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
`endif

endmodule
